// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle RV32I control sequencer. Steps each instruction through
//   FETCH/DECODE/EXECUTE/(MEM|MULDIV)/WB, holds the instruction word in an
//   internal IR, gates datapath strobes per state and handshakes with the
//   instruction and data memories. A 16-bit watchdog traps stalled fetch,
//   memory or mul/div waits. Illegal opcodes also trap. A trap is sticky
//   until reset.
//
//   Optional feature macro: MCU_MULDIV_EN (adds the MULDIV state and the
//   md_start/md_done handshake; otherwise M-extension encodings trap).
//
// Ports
//   clk, reset (async, active low)        clock / reset
//   start                                  leave IDLE
//   instr_code[31:0], instr_valid          instruction memory response
//   d_ready                                data memory access complete
//   md_done                                mul/div result ready
//   instr_req, ir_en, pc_en, d_req,
//   d_wr_en, reg_wr_en, md_start           state-gated strobes
//   ALUSrcMuxSel, ALU_Controls[3:0],
//   RAM2RegWSel[2:0], store_size[1:0],
//   load_size[1:0]                         decode outputs from the IR
//   branch, JAL, JALR                      PC-source qualifiers
//   trap, trap_cause[1:0]                  sticky fault flag and cause
//   state[2:0]                             current FSM state
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | parked after reset, waiting for start
// FETCH    | instr_req high, wait for instr_valid, capture IR
// DECODE   | opcode legality check
// EXECUTE  | branch resolves here, otherwise route to MEM/MULDIV/WB
// MEM      | d_req high, wait for d_ready
// WB       | one-cycle register write and PC update
// MULDIV   | md_start on first cycle, wait for md_done
// TRAP     | all strobes low, held until reset

module multicycle_control_unit #(
  parameter int unsigned TIMEOUT_CYC       = 255,
  parameter bit          RESET_STATE_FETCH = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] instr_code,
  input  logic        instr_valid,
  input  logic        d_ready,
  input  logic        md_done,
  output logic        instr_req,
  output logic        ir_en,
  output logic        pc_en,
  output logic        d_req,
  output logic        d_wr_en,
  output logic        reg_wr_en,
  output logic        ALUSrcMuxSel,
  output logic [3:0]  ALU_Controls,
  output logic [2:0]  RAM2RegWSel,
  output logic [1:0]  store_size,
  output logic [1:0]  load_size,
  output logic        branch,
  output logic        JAL,
  output logic        JALR,
  output logic        md_start,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_MULDIV  = 3'd6,
    S_TRAP    = 3'd7
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_IL    = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam state_t      RESET_ST = RESET_STATE_FETCH ? S_FETCH : S_IDLE;
  // Timeout fires on the cycle whose increment would reach TIMEOUT_CYC.
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYC - 1);

  state_t      st_q, st_d;
  logic [31:0] ir_q;
  logic [15:0] wd_cnt_q, wd_cnt_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;

  logic instr_req_c, ir_en_c, pc_en_c, d_req_c, d_wr_en_c, reg_wr_en_c;
  logic branch_c, jal_c, jalr_c, md_start_c, waiting;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic is_r, is_i, is_il, is_s, is_b, is_lui, is_auipc, is_jal, is_jalr;
  logic is_md, legal, wd_expired;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign funct7   = ir_q[31:25];
  assign is_r     = opcode == OP_R;
  assign is_i     = opcode == OP_I;
  assign is_il    = opcode == OP_IL;
  assign is_s     = opcode == OP_S;
  assign is_b     = opcode == OP_B;
  assign is_lui   = opcode == OP_LUI;
  assign is_auipc = opcode == OP_AUIPC;
  assign is_jal   = opcode == OP_JAL;
  assign is_jalr  = opcode == OP_JALR;
  assign is_md    = is_r && (funct7 == 7'b0000001);
  assign legal    = is_r | is_i | is_il | is_s | is_b | is_lui | is_auipc | is_jal | is_jalr;
  assign wd_expired = wd_cnt_q == WD_LAST;

  // Decode outputs: purely from the IR, so stable from DECODE through WB.
  always_comb begin
    ALU_Controls = 4'b0000;
    ALUSrcMuxSel = !(is_r || is_b);
    RAM2RegWSel  = 3'd0;
    store_size   = funct3[1:0];
    load_size    = 2'b10;
    if (is_r) ALU_Controls = {funct7[5], funct3};
    // Only SRAI carries funct7[5] among I-type ops; ADDI etc. use that bit as imm.
    if (is_i) ALU_Controls = {(funct3 == 3'b101) & funct7[5], funct3};
    if (is_il) RAM2RegWSel = 3'd1;
    else if (is_lui) RAM2RegWSel = 3'd2;
    else if (is_auipc) RAM2RegWSel = 3'd3;
    else if (is_jal || is_jalr) RAM2RegWSel = 3'd4;
`ifdef MCU_MULDIV_EN
    else if (is_md) RAM2RegWSel = 3'd5;
`endif
    case (funct3)
      3'b000:  load_size = 2'b00;
      3'b001:  load_size = 2'b01;
      3'b101:  load_size = 2'b01;
      3'b100:  load_size = 2'b11;
      default: load_size = 2'b10;
    endcase
  end

  always_comb begin
    st_d        = st_q;
    trap_d      = trap_q;
    cause_d     = cause_q;
    instr_req_c = 1'b0;
    ir_en_c     = 1'b0;
    pc_en_c     = 1'b0;
    d_req_c     = 1'b0;
    d_wr_en_c   = 1'b0;
    reg_wr_en_c = 1'b0;
    branch_c    = 1'b0;
    jal_c       = 1'b0;
    jalr_c      = 1'b0;
    md_start_c  = 1'b0;
    waiting     = 1'b0;
    case (st_q)
      S_IDLE: if (start) st_d = S_FETCH;
      S_FETCH: begin
        instr_req_c = 1'b1;
        waiting     = 1'b1;
        if (instr_valid) begin
          ir_en_c = 1'b1;
          st_d    = S_DECODE;
        end else if (wd_expired) begin
          st_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b10;
        end
      end
      S_DECODE: begin
`ifdef MCU_MULDIV_EN
        if (!legal) begin
`else
        if (!legal || is_md) begin
`endif
          st_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b01;
        end else begin
          st_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (is_il || is_s) st_d = S_MEM;
        else if (is_b) begin
          pc_en_c  = 1'b1;
          branch_c = 1'b1;
          st_d     = S_FETCH;
        end
`ifdef MCU_MULDIV_EN
        else if (is_md) st_d = S_MULDIV;
`endif
        else st_d = S_WB;
      end
      S_MEM: begin
        d_req_c   = 1'b1;
        d_wr_en_c = is_s;
        waiting   = 1'b1;
        if (d_ready) begin
          if (is_s) begin
            pc_en_c = 1'b1;
            st_d    = S_FETCH;
          end else begin
            st_d = S_WB;
          end
        end else if (wd_expired) begin
          st_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b11;
        end
      end
      S_WB: begin
        reg_wr_en_c = 1'b1;
        pc_en_c     = 1'b1;
        jal_c       = is_jal;
        jalr_c      = is_jalr;
        st_d        = S_FETCH;
      end
      S_MULDIV: begin
`ifdef MCU_MULDIV_EN
        waiting    = 1'b1;
        // Counter is cleared on entry, so zero marks the first MULDIV cycle.
        md_start_c = wd_cnt_q == 16'd0;
        if (md_done) st_d = S_WB;
        else if (wd_expired) begin
          st_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b11;
        end
`else
        st_d = S_TRAP; trap_d = 1'b1; cause_d = 2'b01;
`endif
      end
      default: ;
    endcase
    wd_cnt_d = (st_d != st_q || !waiting) ? 16'd0 : wd_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= RESET_ST;
      ir_q     <= 32'h0000_0013;
      wd_cnt_q <= 16'd0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      st_q     <= st_d;
      wd_cnt_q <= wd_cnt_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
      if (st_q == S_FETCH && instr_valid) ir_q <= instr_code;
    end
  end

  // Strobes are forced low while reset is held, even though FETCH is the reset state.
  assign instr_req  = instr_req_c & reset;
  assign ir_en      = ir_en_c & reset;
  assign pc_en      = pc_en_c & reset;
  assign d_req      = d_req_c & reset;
  assign d_wr_en    = d_wr_en_c & reset;
  assign reg_wr_en  = reg_wr_en_c & reset;
  assign branch     = branch_c & reset;
  assign JAL        = jal_c & reset;
  assign JALR       = jalr_c & reset;
  assign md_start   = md_start_c & reset;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = st_q;

  logic unused_ok;
`ifdef MCU_MULDIV_EN
  assign unused_ok = ^{ir_q[24:15], ir_q[11:7]};
`else
  assign unused_ok = ^{ir_q[24:15], ir_q[11:7], md_done};
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] instr_code = 32'h0;
  logic        instr_valid = 1'b0;
  logic        d_ready = 1'b0;
  logic        md_done = 1'b0;
  logic        instr_req, ir_en, pc_en, d_req, d_wr_en, reg_wr_en;
  logic        ALUSrcMuxSel;
  logic [3:0]  ALU_Controls;
  logic [2:0]  RAM2RegWSel;
  logic [1:0]  store_size, load_size;
  logic        branch, JAL, JALR, md_start, trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  multicycle_control_unit #(.TIMEOUT_CYC(TO), .RESET_STATE_FETCH(1'b1)) dut (
    .clk(clk), .reset(rst_n), .start(start), .instr_code(instr_code),
    .instr_valid(instr_valid), .d_ready(d_ready), .md_done(md_done),
    .instr_req(instr_req), .ir_en(ir_en), .pc_en(pc_en), .d_req(d_req),
    .d_wr_en(d_wr_en), .reg_wr_en(reg_wr_en), .ALUSrcMuxSel(ALUSrcMuxSel),
    .ALU_Controls(ALU_Controls), .RAM2RegWSel(RAM2RegWSel),
    .store_size(store_size), .load_size(load_size), .branch(branch),
    .JAL(JAL), .JALR(JALR), .md_start(md_start), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] code;
    int fw, mw, mdw;
  } imem_t;

  typedef struct {
    string name;
    int cycles;
    logic [31:0] seq;
    int n_ir, n_reg, n_pc, n_dreq, n_dwr, n_br, n_jal, n_jalr, n_md;
    int end_st, cause;
    bit chk_dec; int alu, src, wsel;
    bit chk_lsz; int lsz;
    bit chk_ssz; int ssz;
  } exp_t;

  imem_t imem_q[$];
  exp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cur_mw = 0;
  int    cur_mdw = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // qual = {md_start, JALR, JAL, branch} pulse counts (0/1 each)
  function automatic exp_t mk(string nm, int cyc, logic [31:0] seq, int n_reg, int n_pc,
                              int n_dreq, int n_dwr, logic [3:0] qual);
    exp_t e;
    e.name = nm; e.cycles = cyc; e.seq = seq; e.n_ir = 1;
    e.n_reg = n_reg; e.n_pc = n_pc; e.n_dreq = n_dreq; e.n_dwr = n_dwr;
    e.n_br = int'(qual[0]); e.n_jal = int'(qual[1]); e.n_jalr = int'(qual[2]); e.n_md = int'(qual[3]);
    e.end_st = 1; e.cause = 0;
    e.chk_dec = 1'b0; e.alu = 0; e.src = 0; e.wsel = 0;
    e.chk_lsz = 1'b0; e.lsz = 0; e.chk_ssz = 1'b0; e.ssz = 0;
    return e;
  endfunction

  function automatic exp_t dec(exp_t e, int alu, int src, int wsel);
    e.chk_dec = 1'b1; e.alu = alu; e.src = src; e.wsel = wsel;
    return e;
  endfunction

  function automatic exp_t trp(exp_t e, int cause);
    e.end_st = 7; e.cause = cause;
    return e;
  endfunction

  task automatic push(input logic [31:0] code, input int fw, input int mw, input int mdw, input exp_t e);
    imem_t m;
    m.code = code; m.fw = fw; m.mw = mw; m.mdw = mdw;
    imem_q.push_back(m);
    sb_q.push_back(e);
  endtask

  // Memory / mul-div responder: drives inputs 1 time unit after each rising edge.
  initial begin
    int fcnt = 0, mcnt = 0, dcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && state == 3'd1 && imem_q.size() > 0) begin
        if (fcnt == imem_q[0].fw) begin
          instr_valid = 1'b1;
          instr_code  = imem_q[0].code;
          cur_mw      = imem_q[0].mw;
          cur_mdw     = imem_q[0].mdw;
          void'(imem_q.pop_front());
          fcnt = 0;
        end else begin
          instr_valid = 1'b0;
          fcnt++;
        end
      end else begin
        instr_valid = 1'b0;
        if (!rst_n) fcnt = 0;
      end
      if (rst_n && state == 3'd4) begin
        d_ready = (mcnt == cur_mw);
        mcnt++;
      end else begin
        d_ready = 1'b0; mcnt = 0;
      end
      if (rst_n && state == 3'd6) begin
        md_done = (dcnt == cur_mdw);
        dcnt++;
      end else begin
        md_done = 1'b0; dcnt = 0;
      end
    end
  end

  // Monitor: one record per instruction, from FETCH entry to the next FETCH entry or TRAP.
  exp_t rec;
  logic active = 1'b0;
  logic [2:0] prev_st = 3'd0;

  task automatic finish_rec(input int end_st);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("unexpected_record", 32'(rec.seq), 32'h0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, ".cycles"}, rec.cycles, e.cycles);
    chk({e.name, ".states"}, rec.seq, e.seq);
    chk({e.name, ".ir_en"}, rec.n_ir, e.n_ir);
    chk({e.name, ".reg_wr_en"}, rec.n_reg, e.n_reg);
    chk({e.name, ".pc_en"}, rec.n_pc, e.n_pc);
    chk({e.name, ".d_req"}, rec.n_dreq, e.n_dreq);
    chk({e.name, ".d_wr_en"}, rec.n_dwr, e.n_dwr);
    chk({e.name, ".quals"}, {rec.n_md[7:0], rec.n_jalr[7:0], rec.n_jal[7:0], rec.n_br[7:0]},
        {e.n_md[7:0], e.n_jalr[7:0], e.n_jal[7:0], e.n_br[7:0]});
    chk({e.name, ".end_state"}, end_st, e.end_st);
    chk({e.name, ".trap_cause"}, 32'(trap_cause), e.cause);
    if (e.chk_dec) begin
      chk({e.name, ".ALU_Controls"}, rec.alu, e.alu);
      chk({e.name, ".ALUSrcMuxSel"}, rec.src, e.src);
      chk({e.name, ".RAM2RegWSel"}, rec.wsel, e.wsel);
    end
    if (e.chk_lsz) chk({e.name, ".load_size"}, rec.lsz, e.lsz);
    if (e.chk_ssz) chk({e.name, ".store_size"}, rec.ssz, e.ssz);
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      active  = 1'b0;
      prev_st = 3'd0;
    end else begin
      if (active && state != prev_st && (state == 3'd1 || state == 3'd7)) begin
        finish_rec(int'(state));
        active = 1'b0;
      end
      if (state == 3'd1 && prev_st != 3'd1) begin
        active = 1'b1;
        rec = mk("", 0, 32'h0, 0, 0, 0, 0, 4'h0);
        rec.n_ir = 0;
      end
      if (active) begin
        rec.cycles++;
        rec.seq = {rec.seq[27:0], 1'b0, state};
        rec.n_ir   += int'(ir_en);
        rec.n_reg  += int'(reg_wr_en);
        rec.n_pc   += int'(pc_en);
        rec.n_dreq += int'(d_req);
        rec.n_dwr  += int'(d_wr_en);
        rec.n_br   += int'(branch);
        rec.n_jal  += int'(JAL);
        rec.n_jalr += int'(JALR);
        rec.n_md   += int'(md_start);
        if (state == 3'd2) begin
          rec.alu = int'(ALU_Controls); rec.src = int'(ALUSrcMuxSel);
          rec.wsel = int'(RAM2RegWSel); rec.lsz = int'(load_size); rec.ssz = int'(store_size);
        end
      end
      prev_st = state;
    end
  end

  task automatic hold_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    imem_q.delete();
    sb_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (sb_q.size() > 0 && n < limit) begin
      @(negedge clk);
      #2 n++;
    end
    chk("drain_pending_records", sb_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "global timeout");
  end

  initial begin
    int bad;
    // Reset values; the NOP in IR decodes as an immediate-source op.
    hold_reset();
    #1;
    chk("reset.strobes", {instr_req, ir_en, pc_en, d_req, d_wr_en, reg_wr_en, md_start, branch, JAL, JALR}, 0);
    chk("reset.state", state, 3'd1);
    chk("reset.trap", {trap, trap_cause}, 3'b000);
    chk("reset.nop_decode", {ALUSrcMuxSel, ALU_Controls, RAM2RegWSel}, {1'b1, 4'b0000, 3'd0});

    // Main instruction stream, zero and non-zero waits.
    push(32'h002081B3, 0, 0, 0, dec(mk("add", 4, 32'h1235, 1, 1, 0, 0, 4'h0), 0, 0, 0));
    begin
      exp_t e = dec(mk("lw_wait3", 8, 32'h12344445, 1, 1, 4, 0, 4'h0), 0, 1, 1);
      e.chk_lsz = 1'b1; e.lsz = 2;
      push(32'h0000A183, 0, 3, 0, e);
      e = dec(mk("sb", 4, 32'h1234, 0, 1, 1, 1, 4'h0), 0, 1, 0);
      e.chk_ssz = 1'b1; e.ssz = 0;
      push(32'h00208023, 0, 0, 0, e);
      e = dec(mk("sw_wait1", 5, 32'h12344, 0, 1, 2, 2, 4'h0), 0, 1, 0);
      e.chk_ssz = 1'b1; e.ssz = 2;
      push(32'h0020A023, 0, 1, 0, e);
    end
    push(32'h00208063, 0, 0, 0, dec(mk("beq", 3, 32'h123, 0, 1, 0, 0, 4'b0001), 0, 0, 0));
    push(32'h123452B7, 0, 0, 0, dec(mk("lui", 4, 32'h1235, 1, 1, 0, 0, 4'h0), 0, 1, 2));
    push(32'h000000EF, 0, 0, 0, dec(mk("jal", 4, 32'h1235, 1, 1, 0, 0, 4'b0010), 0, 1, 4));
    push(32'h000100E7, 0, 0, 0, dec(mk("jalr", 4, 32'h1235, 1, 1, 0, 0, 4'b0100), 0, 1, 4));
    push(32'h402081B3, 0, 0, 0, dec(mk("sub", 4, 32'h1235, 1, 1, 0, 0, 4'h0), 8, 0, 0));
    push(32'h4020D193, 0, 0, 0, dec(mk("srai", 4, 32'h1235, 1, 1, 0, 0, 4'h0), 13, 1, 0));
    push(32'hFFF08193, 0, 0, 0, dec(mk("addi_neg", 4, 32'h1235, 1, 1, 0, 0, 4'h0), 0, 1, 0));
    push(32'h00001197, 0, 0, 0, dec(mk("auipc", 4, 32'h1235, 1, 1, 0, 0, 4'h0), 0, 1, 3));
    begin
      exp_t e = dec(mk("lbu", 5, 32'h12345, 1, 1, 1, 0, 4'h0), 0, 1, 1);
      e.chk_lsz = 1'b1; e.lsz = 3;
      push(32'h0000C183, 0, 0, 0, e);
      e = mk("lhu", 5, 32'h12345, 1, 1, 1, 0, 4'h0);
      e.chk_lsz = 1'b1; e.lsz = 1;
      push(32'h0000D183, 0, 0, 0, e);
    end
    push(32'h002081B3, 2, 0, 0, mk("add_fwait2", 6, 32'h111235, 1, 1, 0, 0, 4'h0));
`ifdef MCU_MULDIV_EN
    push(32'h022081B3, 0, 0, 2, dec(mk("mul", 7, 32'h1236665, 1, 1, 0, 0, 4'b1000), 0, 0, 5));
`else
    push(32'h022081B3, 0, 0, 2, trp(mk("mul_illegal", 2, 32'h12, 0, 0, 0, 0, 4'h0), 1));
`endif
    release_reset();
    drain(400);

    // Illegal opcode: sticky trap, cleared by reset.
    hold_reset();
    push(32'h0000007F, 0, 0, 0, trp(mk("illegal_7f", 2, 32'h12, 0, 0, 0, 0, 4'h0), 1));
    release_reset();
    drain(50);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      #1;
      if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'b01 ||
          {instr_req, pc_en, d_req, d_wr_en, reg_wr_en, md_start} !== 6'b0) bad++;
    end
    chk("trap_hold_cycles_bad", bad, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("trap_reset_clear", {state, trap, trap_cause}, {3'd1, 1'b0, 2'b00});

    // Load with d_ready never arriving: memory timeout.
    hold_reset();
    begin
      exp_t e = trp(mk("lw_mem_timeout", 7, 32'h1234444, 0, 0, 4, 0, 4'h0), 3);
      e.chk_lsz = 1'b1; e.lsz = 2;
      push(32'h0000A183, 0, 1000, 0, e);
    end
    release_reset();
    drain(50);

    // Fetch timeout after one instruction when instr_valid never returns.
    hold_reset();
    push(32'h002081B3, 0, 0, 0, mk("add_then_idle", 4, 32'h1235, 1, 1, 0, 0, 4'h0));
    begin
      exp_t e = trp(mk("fetch_timeout", 4, 32'h1111, 0, 0, 0, 0, 4'h0), 2);
      e.n_ir = 0;
      sb_q.push_back(e);
    end
    release_reset();
    drain(50);

    // Reset asserted mid-load: strobes drop at once, next instruction runs cleanly.
    hold_reset();
    imem_q.push_back('{code: 32'h0000A183, fw: 0, mw: 1000, mdw: 0});
    release_reset();
    bad = 0;
    while (state !== 3'd4 && bad < 20) begin
      @(negedge clk);
      bad++;
    end
    chk("midreset_reached_mem", state, 3'd4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_async", {state, d_req, d_wr_en, reg_wr_en, pc_en}, {3'd1, 4'b0000});
    imem_q.delete();
    sb_q.delete();
    push(32'h002081B3, 0, 0, 0, mk("add_after_reset", 4, 32'h1235, 1, 1, 0, 0, 4'h0));
    release_reset();
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
